// File: rtl/alu_serial_ctrl_if.sv
// rtl/alu_serial_ctrl_if.sv - request/response bundle between decode and the bit-serial ALU
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       opr_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    modport master (
        output start_i, src1_i, src2_i, opr_i,
        input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );

    modport slave (
        input  start_i, src1_i, src2_i, opr_i,
        output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU sequencer reusing one 1-bit slice, LSB first
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_serial_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       opr_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;

    logic             a_bit;
    logic             b_bit;
    logic             s_sum;
    logic             s_cout;
    logic             s_ovf;
    logic             s_set;
    logic             s_res;
    logic             last_bit;
    logic             arith;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] final_res;

    // The single reused slice; its less input is tied low, SLT is patched on the last bit.
    always_comb begin
        a_bit  = a_sh[0] ^ opr_q[3];
        b_bit  = b_sh[0] ^ opr_q[2];
        s_sum  = a_bit ^ b_bit ^ carry;
        s_cout = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
        s_ovf  = carry ^ s_cout;
        s_set  = s_ovf ^ s_sum;
        s_res  = 1'b0;
        case (opr_q[1:0])
            2'b00:   s_res = a_bit & b_bit;
            2'b01:   s_res = a_bit | b_bit;
            2'b10:   s_res = s_sum;
            default: s_res = 1'b0;
        endcase
    end

    always_comb begin
        last_bit  = (cnt == CW'(WIDTH - 1));
        arith     = opr_q[1];
        shifted   = {s_res, res_sh};
        final_res = (opr_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, s_set} : shifted;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            opr_q    <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            res_sh   <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        a_sh  <= bus.src1_i;
                        b_sh  <= bus.src2_i;
                        opr_q <= bus.opr_i;
                        cnt   <= '0;
                        carry <= bus.opr_i[2];
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_sh <= shifted[WIDTH-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= s_cout;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        result_q <= final_res;
                        zero_q   <= (final_res == '0);
                        cout_q   <= arith & s_cout;
                        ovf_q    <= arith & s_ovf;
                        state    <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o     = (state == S_RUN);
    assign bus.done_o     = (state == S_DONE);
    assign bus.result_o   = result_q;
    assign bus.zero_o     = zero_q;
    assign bus.cout_o     = cout_q;
    assign bus.overflow_o = ovf_q;
endmodule
